// File: rtl/fp_addsub_pipe_ctl_if.sv
// Operand/result handshake bundle for the floating-point add/sub unit.
// The producer drives the operands and the consumer drives out_ready.
interface fp_addsub_pipe_ctl_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = EXP_W + MAN_W + 1;

    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_op;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_z;
    logic [2:0]   out_flags;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_a, in_b, in_op, in_valid, out_ready,
        input  in_ready, out_z, out_flags, out_valid
    );

    modport slave (
        input  in_a, in_b, in_op, in_valid, out_ready,
        output in_ready, out_z, out_flags, out_valid
    );
endinterface

// File: rtl/fp_addsub_pipe_ctl.sv
// Multi-cycle IEEE-754 adder/subtractor, round-to-nearest-even, one operation in flight.
// Flags are {invalid, overflow, inexact}.
module fp_addsub_pipe_ctl #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic clk,
    input  logic rst,
    fp_addsub_pipe_ctl_if.slave bus
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int MW = MAN_W + 4;   // hidden bit + fraction + guard/round/sticky
    localparam int EW = EXP_W + 1;   // one spare bit so overflow is visible before packing
    localparam logic [EW-1:0] EXP_ONES = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EW-1:0] EXP_ONE  = EW'(1);

    typedef enum logic [3:0] {IDLE, UNPACK, SPECIAL, ALIGN, ADD, NORM, ROUND, PACK, OUT} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, z_q, z_d;
    logic            sa_q, sa_d, sb_q, sb_d, sz_q, sz_d;
    logic [EW-1:0]   ea_q, ea_d, eb_q, eb_d, ez_q, ez_d;
    logic [MW-1:0]   ma_q, ma_d, mb_q, mb_d;
    logic [MW:0]     sum_q, sum_d;
    logic [2:0]      flags_q, flags_d;
    logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;

    logic            a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, round_up;
    logic [W-1:0]    a_raw, b_raw;
    logic [EW-1:0]   diff_ab, diff_ba;
    logic [MAN_W+1:0] rnd;

    assign a_nan  = (ea_q == EXP_ONES) && (ma_q[MW-2:3] != '0);
    assign b_nan  = (eb_q == EXP_ONES) && (mb_q[MW-2:3] != '0);
    assign a_inf  = (ea_q == EXP_ONES) && (ma_q[MW-2:3] == '0);
    assign b_inf  = (eb_q == EXP_ONES) && (mb_q[MW-2:3] == '0);
    assign a_zero = (ea_q == '0) && (ma_q[MW-2:3] == '0);
    assign b_zero = (eb_q == '0) && (mb_q[MW-2:3] == '0);
    assign a_raw  = {sa_q, ea_q[EXP_W-1:0], ma_q[MW-2:3]};
    assign b_raw  = {sb_q, eb_q[EXP_W-1:0], mb_q[MW-2:3]};
    assign diff_ab = ea_q - eb_q;
    assign diff_ba = eb_q - ea_q;
    assign round_up = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
    assign rnd = {1'b0, sum_q[MW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};

    always_comb begin
        state_d = state_q;
        a_d = a_q; b_d = b_q; z_d = z_q;
        sa_d = sa_q; sb_d = sb_q; sz_d = sz_q;
        ea_d = ea_q; eb_d = eb_q; ez_d = ez_q;
        ma_d = ma_q; mb_d = mb_q; sum_d = sum_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: if (bus.in_valid && in_ready_q) begin
                a_d = bus.in_a;
                b_d = {bus.in_b[W-1] ^ bus.in_op, bus.in_b[W-2:0]};
                flags_d = '0;
                state_d = UNPACK;
            end
            UNPACK: begin
                sa_d = a_q[W-1];  ea_d = {1'b0, a_q[W-2:MAN_W]};  ma_d = {1'b0, a_q[MAN_W-1:0], 3'b000};
                sb_d = b_q[W-1];  eb_d = {1'b0, b_q[W-2:MAN_W]};  mb_d = {1'b0, b_q[MAN_W-1:0], 3'b000};
                state_d = SPECIAL;
            end
            SPECIAL: begin
                state_d = OUT;
                if (a_nan || b_nan || (a_inf && b_inf && (sa_q != sb_q))) begin
                    z_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                    flags_d[2] = 1'b1;
                end else if (a_inf)              z_d = a_raw;
                else if (b_inf)                  z_d = b_raw;
                else if (a_zero && b_zero)       z_d = {sa_q & sb_q, {(W-1){1'b0}}};
                else if (a_zero)                 z_d = b_raw;
                else if (b_zero)                 z_d = a_raw;
                else begin
                    // Denormals behave as exponent 1 without the hidden bit.
                    ma_d = {ea_q != '0, ma_q[MW-2:0]};
                    mb_d = {eb_q != '0, mb_q[MW-2:0]};
                    ea_d = (ea_q == '0) ? EXP_ONE : ea_q;
                    eb_d = (eb_q == '0) ? EXP_ONE : eb_q;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (ea_q == eb_q) begin
                    state_d = ADD;
                end else if (ea_q < eb_q) begin
                    ea_d = (32'(diff_ba) > MAN_W + 4) ? eb_q : ea_q + EXP_ONE;
                    ma_d = (32'(diff_ba) > MAN_W + 4) ? MW'(|ma_q)
                                                      : {1'b0, ma_q[MW-1:2], |ma_q[1:0]};
                end else begin
                    eb_d = (32'(diff_ab) > MAN_W + 4) ? ea_q : eb_q + EXP_ONE;
                    mb_d = (32'(diff_ab) > MAN_W + 4) ? MW'(|mb_q)
                                                      : {1'b0, mb_q[MW-1:2], |mb_q[1:0]};
                end
            end
            ADD: begin
                ez_d = ea_q;
                state_d = NORM;
                if (sa_q == sb_q) begin
                    sum_d = {1'b0, ma_q} + {1'b0, mb_q};  sz_d = sa_q;
                end else if (ma_q > mb_q) begin
                    sum_d = {1'b0, ma_q} - {1'b0, mb_q};  sz_d = sa_q;
                end else if (mb_q > ma_q) begin
                    sum_d = {1'b0, mb_q} - {1'b0, ma_q};  sz_d = sb_q;
                end else begin
                    sum_d = '0;  sz_d = 1'b0;
                end
            end
            NORM: begin
                if (sum_q[MW]) begin
                    sum_d = {1'b0, sum_q[MW:2], sum_q[1] | sum_q[0]};
                    ez_d = ez_q + EXP_ONE;
                end else if (!sum_q[MW-1] && (ez_q > EXP_ONE) && (sum_q != '0)) begin
                    sum_d = {sum_q[MW-1:0], 1'b0};
                    ez_d = ez_q - EXP_ONE;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                flags_d[0] = sum_q[2] | sum_q[1] | sum_q[0];
                if (rnd[MAN_W+1]) begin
                    sum_d = {1'b0, rnd[MAN_W+1:1], 3'b000};
                    ez_d = ez_q + EXP_ONE;
                end else begin
                    sum_d = {1'b0, rnd[MAN_W:0], 3'b000};
                end
                state_d = PACK;
            end
            PACK: begin
                if (ez_q >= EXP_ONES) begin
                    z_d = {sz_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_d[1:0] = 2'b11;
                end else begin
                    z_d = {sz_q, (sum_q[MW-1] ? ez_q[EXP_W-1:0] : {EXP_W{1'b0}}), sum_q[MW-2:3]};
                end
                state_d = OUT;
            end
            OUT: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q <= '0; b_q <= '0; z_q <= '0;
            sa_q <= 1'b0; sb_q <= 1'b0; sz_q <= 1'b0;
            ea_q <= '0; eb_q <= '0; ez_q <= '0;
            ma_q <= '0; mb_q <= '0; sum_q <= '0;
            flags_q <= '0;
            in_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d; b_q <= b_d; z_q <= z_d;
            sa_q <= sa_d; sb_q <= sb_d; sz_q <= sz_d;
            ea_q <= ea_d; eb_q <= eb_d; ez_q <= ez_d;
            ma_q <= ma_d; mb_q <= mb_d; sum_q <= sum_d;
            flags_q <= flags_d;
            in_ready_q <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_z     = z_q;
    assign bus.out_flags = flags_q;
endmodule

// File: tb/tb_fp_addsub_pipe_ctl.sv
// Bench for fp_addsub_pipe_ctl: directed cases, backpressure, mid-op reset and random
// operands checked against an exact wide-integer reference of IEEE add with RNE.
module tb_fp_addsub_pipe_ctl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    fp_addsub_pipe_ctl_if #(.EXP_W(8), .MAN_W(23)) bus ();
    fp_addsub_pipe_ctl #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Exact reference: every finite binary32 is an integer multiple of 2^-149.
    function automatic void ref_add(input logic [31:0] a, input logic [31:0] bi, input logic op,
                                    output logic [31:0] z, output logic [2:0] f);
        logic [31:0] b;
        logic sa, sb, s;
        logic [7:0] ea, eb;
        logic [22:0] fa, fb;
        logic [299:0] va, vb, mag, rem, half;
        logic [24:0] keep;
        int p, sh, e;
        b = {bi[31] ^ op, bi[30:0]};
        sa = a[31]; ea = a[30:23]; fa = a[22:0];
        sb = b[31]; eb = b[30:23]; fb = b[22:0];
        f = 3'b000;
        if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0) ||
            (ea == 8'hFF && eb == 8'hFF && sa != sb)) begin
            z = 32'h7FC00000; f = 3'b100; return;
        end
        if (ea == 8'hFF) begin z = a; return; end
        if (eb == 8'hFF) begin z = b; return; end
        if (a[30:0] == 0 && b[30:0] == 0) begin z = {sa & sb, 31'b0}; return; end
        if (a[30:0] == 0) begin z = b; return; end
        if (b[30:0] == 0) begin z = a; return; end
        va = 300'({ea != 0, fa}) << ((ea == 0) ? 0 : int'(ea) - 1);
        vb = 300'({eb != 0, fb}) << ((eb == 0) ? 0 : int'(eb) - 1);
        if (sa == sb)     begin mag = va + vb; s = sa; end
        else if (va > vb) begin mag = va - vb; s = sa; end
        else              begin mag = vb - va; s = sb; end
        if (mag == 0) begin z = 32'h0; return; end
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p <= 23) begin z = {s, mag[30:0]}; return; end
        sh = p - 23;
        keep = 25'(mag >> sh);
        rem = mag & ((300'(1) << sh) - 300'(1));
        half = 300'(1) << (sh - 1);
        if (rem > half || (rem == half && keep[0])) keep = keep + 25'd1;
        if (rem != 0) f[0] = 1'b1;
        if (keep[24]) begin keep = keep >> 1; sh++; end
        e = sh + 1;
        if (e >= 255) begin z = {s, 8'hFF, 23'b0}; f = 3'b011; end
        else z = {s, 8'(e), keep[22:0]};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                          output logic [31:0] z, output logic [2:0] f, output logic ok);
        int n;
        ok = 1'b0; z = '0; f = '0;
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
        bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
        if (bus.out_valid) begin z = bus.out_z; f = bus.out_flags; ok = 1'b1; end
        @(negedge clk);
    endtask

    task automatic op_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic op, input logic [31:0] ez, input logic [2:0] ef);
        logic [31:0] z;
        logic [2:0] f;
        logic ok;
        run_op(a, b, op, z, f, ok);
        check({tag, "_done"}, 64'(ok), 64'd1);
        check({tag, "_z"}, 64'(z), 64'(ez));
        check({tag, "_flags"}, 64'(f), 64'(ef));
    endtask

    function automatic logic [31:0] rnd_operand(input logic [31:0] near);
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 15))
            0:       v[30:23] = 8'hFF;
            1:       v[30:23] = 8'h00;
            2:       v[30:0] = '0;
            3:       v = near ^ 32'h80000000;
            4, 5, 6, 7, 8, 9: v[30:23] = near[30:23] ^ 8'($urandom_range(0, 3));
            10, 11:  v[30:23] = near[30:23] ^ 8'($urandom_range(0, 31));
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] a, b, z, ez, hold_z;
        logic [2:0] f, ef;
        logic op, ok;
        int n, xfers, vseen;
        bus.in_a = '0; bus.in_b = '0; bus.in_op = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_z", 64'(bus.out_z), 64'd0);
        check("rst_out_flags", 64'(bus.out_flags), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);

        op_check("one_plus_two", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
        op_check("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
        op_check("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
        op_check("max_plus_max", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
        op_check("tie_even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
        op_check("denorm_sum", 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000);
        op_check("zero_minus_zero", 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 3'b000);
        op_check("neg_zeros", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
        op_check("zero_plus_x", 32'h00000000, 32'h40490FDB, 1'b1, 32'hC0490FDB, 3'b000);

        // Backpressure: result must sit still and the input side stay closed.
        ref_add(32'h3FC00000, 32'h3E000000, 1'b1, ez, ef);
        @(negedge clk);
        bus.in_a = 32'h3FC00000; bus.in_b = 32'h3E000000; bus.in_op = 1'b1;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
        check("bp_valid_rose", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_z_hold", 64'(bus.out_z), 64'(ez));
            check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
            check("bp_valid_hold", 64'(bus.out_valid), 64'd1);
        end
        check("bp_flags", 64'(bus.out_flags), 64'(ef));
        bus.out_ready = 1'b1;
        xfers = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid && bus.out_ready) xfers++;
            @(negedge clk);
        end
        check("bp_single_xfer", 64'(xfers), 64'd1);

        // Reset during alignment (24 shift steps needed for this pair).
        bus.in_a = 32'h3F800000; bus.in_b = 32'h33800000; bus.in_op = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_in_ready_rst", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        vseen = 0;
        @(negedge clk);
        if (bus.out_valid) vseen++;
        @(negedge clk);
        check("abort_in_ready_back", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 60; i++) begin
            if (bus.out_valid) vseen++;
            @(negedge clk);
        end
        check("abort_no_output", 64'(vseen), 64'd0);

        a = 32'h3F800000;
        for (int i = 0; i < 400; i++) begin
            a = rnd_operand(a);
            b = rnd_operand(a);
            op = 1'($urandom);
            ref_add(a, b, op, ez, ef);
            run_op(a, b, op, z, f, ok);
            check("rand_done", 64'(ok), 64'd1);
            check("rand_z", {a, b} ^ 64'(z), {a, b} ^ 64'(ez));
            check("rand_flags", 64'(f), 64'(ef));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
